// File: rtl/ctrl_pipe_hazard.sv
// Control pipeline ID->EX->MEM->WB with hazard stall, branch flush and perf counters.
// Build option: define CTRL_FWD_EN to enable the EX operand forwarding unit.
module ctrl_pipe_hazard #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic             id_regwrite,
    input  logic             id_alusrc,
    input  logic             id_memwrite,
    input  logic             id_branch,
    input  logic             id_memread,
    input  logic             id_memtoreg,
    input  logic [1:0]       id_aluop,
    input  logic [6:0]       id_op,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             ex_br_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             ex_regwrite,
    output logic             ex_alusrc,
    output logic             ex_memwrite,
    output logic             ex_branch,
    output logic             ex_memread,
    output logic             ex_memtoreg,
    output logic [1:0]       ex_aluop,
    output logic [6:0]       ex_op,
    output logic [RA_W-1:0]  ex_rd,
    output logic             mem_regwrite,
    output logic             mem_memwrite,
    output logic             mem_memread,
    output logic             mem_memtoreg,
    output logic [RA_W-1:0]  mem_rd,
    output logic             wb_regwrite,
    output logic             wb_memtoreg,
    output logic [RA_W-1:0]  wb_rd,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic            regwrite;
        logic            alusrc;
        logic            memwrite;
        logic            branch;
        logic            memread;
        logic            memtoreg;
        logic [1:0]      aluop;
        logic [6:0]      op;
        logic [RA_W-1:0] rd;
    } ex_ctrl_t;

    typedef struct packed {
        logic            regwrite;
        logic            memwrite;
        logic            memread;
        logic            memtoreg;
        logic [RA_W-1:0] rd;
    } mem_ctrl_t;

    typedef struct packed {
        logic            regwrite;
        logic            memtoreg;
        logic [RA_W-1:0] rd;
    } wb_ctrl_t;

    localparam logic [RA_W-1:0]  RA_ZERO    = {RA_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam ex_ctrl_t         EX_BUBBLE  = {$bits(ex_ctrl_t){1'b0}};
    localparam mem_ctrl_t        MEM_BUBBLE = {$bits(mem_ctrl_t){1'b0}};
    localparam wb_ctrl_t         WB_BUBBLE  = {$bits(wb_ctrl_t){1'b0}};

    ex_ctrl_t         ex_q, ex_d;
    mem_ctrl_t        mem_q, mem_d;
    wb_ctrl_t         wb_q, wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             use_rs1_s, use_rs2_s, ex_hit_s, load_use_s, hazard_s;
    logic             stall_s, flush_s, bubble_s;

    function automatic logic rs_hit(input logic [RA_W-1:0] rd, input logic [RA_W-1:0] rs1,
                                    input logic [RA_W-1:0] rs2, input logic u1, input logic u2);
        rs_hit = (rd != RA_ZERO) && ((u1 && (rs1 == rd)) || (u2 && (rs2 == rd)));
    endfunction

    // Which source registers the ID opcode actually reads
    always_comb begin
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b0;
        case (id_op)
            7'b0110111, 7'b0010111, 7'b1101111: begin use_rs1_s = 1'b0; use_rs2_s = 1'b0; end
            7'b0110011, 7'b0100011, 7'b1100011: begin use_rs1_s = 1'b1; use_rs2_s = 1'b1; end
            default:                            begin use_rs1_s = 1'b1; use_rs2_s = 1'b0; end
        endcase
    end

    // Hazard detection; a taken branch overrides any stall
    always_comb begin
        ex_hit_s   = id_valid & rs_hit(ex_q.rd, id_rs1, id_rs2, use_rs1_s, use_rs2_s);
        load_use_s = ex_hit_s & ex_q.memread;
`ifdef CTRL_FWD_EN
        hazard_s   = load_use_s;
`else
        hazard_s   = load_use_s | (ex_hit_s & ex_q.regwrite) |
                     (id_valid & mem_q.regwrite & rs_hit(mem_q.rd, id_rs1, id_rs2, use_rs1_s, use_rs2_s));
`endif
        flush_s    = ex_br_taken & ~reset;
        stall_s    = hazard_s & ~ex_br_taken & ~reset;
        bubble_s   = ex_br_taken | hazard_s | ~id_valid;
    end

    // Next-state of the stage registers and saturating counters
    always_comb begin
        ex_d = EX_BUBBLE;
        if (!bubble_s) begin
            ex_d.regwrite = id_regwrite;
            ex_d.alusrc   = id_alusrc;
            ex_d.memwrite = id_memwrite;
            ex_d.branch   = id_branch;
            ex_d.memread  = id_memread;
            ex_d.memtoreg = id_memtoreg;
            ex_d.aluop    = id_aluop;
            ex_d.op       = id_op;
            ex_d.rd       = id_rd;
        end else begin
            ex_d = EX_BUBBLE;
        end
        mem_d.regwrite = ex_q.regwrite;
        mem_d.memwrite = ex_q.memwrite;
        mem_d.memread  = ex_q.memread;
        mem_d.memtoreg = ex_q.memtoreg;
        mem_d.rd       = ex_q.rd;
        wb_d.regwrite  = mem_q.regwrite;
        wb_d.memtoreg  = mem_q.memtoreg;
        wb_d.rd        = mem_q.rd;
        if (stall_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (flush_s && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Pipeline and counter state
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q        <= EX_BUBBLE;
            mem_q       <= MEM_BUBBLE;
            wb_q        <= WB_BUBBLE;
            stall_cnt_q <= CNT_ZERO;
            flush_cnt_q <= CNT_ZERO;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

`ifdef CTRL_FWD_EN
    logic [RA_W-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
    logic [1:0]      fwd_a_s, fwd_b_s;

    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs, input mem_ctrl_t m, input wb_ctrl_t w);
        if (m.regwrite && (m.rd != RA_ZERO) && (m.rd == rs)) begin
            fwd_sel = 2'b10;
        end else if (w.regwrite && (w.rd != RA_ZERO) && (w.rd == rs)) begin
            fwd_sel = 2'b01;
        end else begin
            fwd_sel = 2'b00;
        end
    endfunction

    // Only sources actually read travel with the instruction; bubbles carry x0
    always_comb begin
        ex_rs1_d = (!bubble_s && use_rs1_s) ? id_rs1 : RA_ZERO;
        ex_rs2_d = (!bubble_s && use_rs2_s) ? id_rs2 : RA_ZERO;
        if (reset) begin
            fwd_a_s = 2'b00;
            fwd_b_s = 2'b00;
        end else begin
            fwd_a_s = fwd_sel(ex_rs1_q, mem_q, wb_q);
            fwd_b_s = fwd_sel(ex_rs2_q, mem_q, wb_q);
        end
    end

    // EX source register fields for the forwarding compare
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_rs1_q <= RA_ZERO;
            ex_rs2_q <= RA_ZERO;
        end else begin
            ex_rs1_q <= ex_rs1_d;
            ex_rs2_q <= ex_rs2_d;
        end
    end

    assign fwd_a = fwd_a_s;
    assign fwd_b = fwd_b_s;
`else
    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
`endif

    assign pc_write     = ~stall_s;
    assign ifid_write   = ~stall_s;
    assign ifid_flush   = flush_s;
    assign ex_regwrite  = ex_q.regwrite;
    assign ex_alusrc    = ex_q.alusrc;
    assign ex_memwrite  = ex_q.memwrite;
    assign ex_branch    = ex_q.branch;
    assign ex_memread   = ex_q.memread;
    assign ex_memtoreg  = ex_q.memtoreg;
    assign ex_aluop     = ex_q.aluop;
    assign ex_op        = ex_q.op;
    assign ex_rd        = ex_q.rd;
    assign mem_regwrite = mem_q.regwrite;
    assign mem_memwrite = mem_q.memwrite;
    assign mem_memread  = mem_q.memread;
    assign mem_memtoreg = mem_q.memtoreg;
    assign mem_rd       = mem_q.rd;
    assign wb_regwrite  = wb_q.regwrite;
    assign wb_memtoreg  = wb_q.memtoreg;
    assign wb_rd        = wb_q.rd;
    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Scoreboard bench for ctrl_pipe_hazard: directed scenarios plus constrained-random traffic.
// Counters are instantiated 4 bits wide so saturation is reachable quickly.
module tb_ctrl_pipe_hazard;

    localparam int CW   = 4;
    localparam int MAXC = 15;
    localparam logic [6:0] OP_LD = 7'b0000011, OP_R = 7'b0110011, OP_ST = 7'b0100011, OP_BR = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111, OP_I = 7'b0010011;
`ifdef CTRL_FWD_EN
    localparam int LU_ST = 1, RAW_ST = 0;
    localparam logic [1:0] FWD_LD = 2'b01, FWD_RAW = 2'b10;
`else
    localparam int LU_ST = 2, RAW_ST = 2;
    localparam logic [1:0] FWD_LD = 2'b00, FWD_RAW = 2'b00;
`endif

    typedef struct packed {
        logic rw, als, mw, br, mr, m2r;
        logic [1:0] aluop;
        logic [6:0] op;
        logic [4:0] rd, rs1, rs2;
    } st_t;

    typedef struct packed {
        st_t ex;
        st_t mem;
        st_t wb;
        int  sc;
        int  fc;
    } exp_t;

    logic clk, reset, id_valid, id_regwrite, id_alusrc, id_memwrite, id_branch, id_memread, id_memtoreg;
    logic [1:0] id_aluop;
    logic [6:0] id_op;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic ex_br_taken, pc_write, ifid_write, ifid_flush;
    logic ex_regwrite, ex_alusrc, ex_memwrite, ex_branch, ex_memread, ex_memtoreg;
    logic [1:0] ex_aluop;
    logic [6:0] ex_op;
    logic [4:0] ex_rd, mem_rd, wb_rd;
    logic mem_regwrite, mem_memwrite, mem_memread, mem_memtoreg, wb_regwrite, wb_memtoreg;
    logic [1:0] fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_errors = 0;
    exp_t sb[$];
    st_t m_ex = '0, m_mem = '0, m_wb = '0;
    int m_sc = 0, m_fc = 0;

    ctrl_pipe_hazard #(.RA_W(5), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_regwrite(id_regwrite), .id_alusrc(id_alusrc), .id_memwrite(id_memwrite),
        .id_branch(id_branch), .id_memread(id_memread), .id_memtoreg(id_memtoreg),
        .id_aluop(id_aluop), .id_op(id_op), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_br_taken(ex_br_taken), .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .ex_regwrite(ex_regwrite), .ex_alusrc(ex_alusrc), .ex_memwrite(ex_memwrite),
        .ex_branch(ex_branch), .ex_memread(ex_memread), .ex_memtoreg(ex_memtoreg),
        .ex_aluop(ex_aluop), .ex_op(ex_op), .ex_rd(ex_rd),
        .mem_regwrite(mem_regwrite), .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
        .mem_memtoreg(mem_memtoreg), .mem_rd(mem_rd),
        .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic st_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        st_t s;
        s = '0;
        s.op = op; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2;
        case (op)
            OP_LD:   begin s.rw = 1'b1; s.als = 1'b1; s.mr = 1'b1; s.m2r = 1'b1; end
            OP_R:    begin s.rw = 1'b1; s.aluop = 2'b10; end
            OP_ST:   begin s.als = 1'b1; s.mw = 1'b1; end
            OP_BR:   begin s.br = 1'b1; s.aluop = 2'b01; end
            default: begin s.rw = 1'b1; s.als = 1'b1; end
        endcase
        return s;
    endfunction

    function automatic bit reads_rs1(input logic [6:0] op);
        return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    endfunction

    function automatic bit reads_rs2(input logic [6:0] op);
        return (op == OP_R || op == OP_ST || op == OP_BR);
    endfunction

    function automatic bit dep(input logic [4:0] rd, input st_t i);
        if (rd == 5'd0) return 1'b0;
        return (reads_rs1(i.op) && i.rs1 == rd) || (reads_rs2(i.op) && i.rs2 == rd);
    endfunction

    function automatic logic [31:0] ex_bits(input st_t s);
        return {12'd0, s.rw, s.als, s.mw, s.br, s.mr, s.m2r, s.aluop, s.op, s.rd};
    endfunction

`ifdef CTRL_FWD_EN
    function automatic logic [1:0] fwd_exp(input logic [4:0] rs);
        if (m_mem.rw && m_mem.rd != 5'd0 && m_mem.rd == rs) return 2'b10;
        if (m_wb.rw && m_wb.rd != 5'd0 && m_wb.rd == rs) return 2'b01;
        return 2'b00;
    endfunction
`endif

    // One clock: drive at negedge, check combinational outputs, predict, check registers next negedge
    task automatic step(input bit rst, input bit v, input st_t ins, input bit br,
                        output bit stl, output logic obs_pc, output logic obs_fl);
        bit haz, stall, flush;
        logic [1:0] efa, efb;
        exp_t e, got;
        reset = rst; id_valid = v; ex_br_taken = br;
        id_regwrite = ins.rw; id_alusrc = ins.als; id_memwrite = ins.mw; id_branch = ins.br;
        id_memread = ins.mr; id_memtoreg = ins.m2r; id_aluop = ins.aluop; id_op = ins.op;
        id_rd = ins.rd; id_rs1 = ins.rs1; id_rs2 = ins.rs2;
        #1;
        haz = v && m_ex.mr && dep(m_ex.rd, ins);
`ifdef CTRL_FWD_EN
        efa = fwd_exp(m_ex.rs1);
        efb = fwd_exp(m_ex.rs2);
`else
        haz = haz || (v && ((m_ex.rw && dep(m_ex.rd, ins)) || (m_mem.rw && dep(m_mem.rd, ins))));
        efa = 2'b00;
        efb = 2'b00;
`endif
        if (rst) begin efa = 2'b00; efb = 2'b00; end
        flush = br && !rst;
        stall = haz && !br && !rst;
        check_eq("pc_write", pc_write, !stall);
        check_eq("ifid_write", ifid_write, !stall);
        check_eq("ifid_flush", ifid_flush, flush);
        check_eq("fwd_a", fwd_a, efa);
        check_eq("fwd_b", fwd_b, efb);
        stl = stall; obs_pc = pc_write; obs_fl = ifid_flush;
        e = '0;
        if (!rst) begin
            e.wb = m_mem;
            e.mem = m_ex;
            if (v && !haz && !br) begin
                e.ex = ins;
                e.ex.rs1 = reads_rs1(ins.op) ? ins.rs1 : 5'd0;
                e.ex.rs2 = reads_rs2(ins.op) ? ins.rs2 : 5'd0;
            end
            e.sc = (stall && m_sc != MAXC) ? m_sc + 1 : m_sc;
            e.fc = (flush && m_fc != MAXC) ? m_fc + 1 : m_fc;
        end
        sb.push_back(e);
        @(posedge clk);
        m_ex = e.ex; m_mem = e.mem; m_wb = e.wb; m_sc = e.sc; m_fc = e.fc;
        @(negedge clk);
        got = sb.pop_front();
        check_eq("ex_stage", {12'd0, ex_regwrite, ex_alusrc, ex_memwrite, ex_branch, ex_memread,
                              ex_memtoreg, ex_aluop, ex_op, ex_rd}, ex_bits(got.ex));
        check_eq("mem_stage", {mem_regwrite, mem_memwrite, mem_memread, mem_memtoreg, mem_rd},
                 {got.mem.rw, got.mem.mw, got.mem.mr, got.mem.m2r, got.mem.rd});
        check_eq("wb_stage", {wb_regwrite, wb_memtoreg, wb_rd}, {got.wb.rw, got.wb.m2r, got.wb.rd});
        check_eq("stall_cnt", stall_cnt, got.sc);
        check_eq("flush_cnt", flush_cnt, got.fc);
    endtask

    // Present an instruction in ID until it is accepted; returns bubbles spent
    task automatic issue(input st_t ins, output int nst);
        bit s;
        logic p, f;
        int k;
        nst = 0;
        s = 1'b1;
        k = 0;
        while (s && k < 6) begin
            step(1'b0, 1'b1, ins, 1'b0, s, p, f);
            if (s) nst++;
            k++;
        end
        check_eq("issue_bound", {31'd0, s}, 32'd0);
    endtask

    task automatic do_reset();
        bit s;
        logic p, f;
        repeat (2) step(1'b1, 1'b0, st_t'(0), 1'b0, s, p, f);
    endtask

    initial begin
        bit s, v, br, rst;
        logic p, f;
        int n;
        st_t r;
        logic [6:0] ops [8];
        ops = '{OP_LD, OP_R, OP_ST, OP_BR, OP_LUI, OP_AUIPC, OP_JAL, OP_I};
        reset = 1'b1; id_valid = 1'b0; ex_br_taken = 1'b0;
        {id_regwrite, id_alusrc, id_memwrite, id_branch, id_memread, id_memtoreg} = 6'd0;
        id_aluop = 2'd0; id_op = 7'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
        @(negedge clk);

        // reset with random ID contents
        repeat (2) begin
            r = st_t'($urandom);
            step(1'b1, 1'($urandom), r, 1'($urandom), s, p, f);
        end
        check_eq("t1_pc", pc_write, 32'd1);
        check_eq("t1_stages", {ex_regwrite, ex_memread, ex_rd, mem_regwrite, mem_rd, wb_regwrite, wb_rd}, 32'd0);
        check_eq("t1_cnt", {stall_cnt, flush_cnt}, 32'd0);

        // load-use
        do_reset();
        step(1'b0, 1'b1, mk(OP_LD, 5'd5, 5'd1, 5'd0), 1'b0, s, p, f);
        issue(mk(OP_R, 5'd6, 5'd5, 5'd7), n);
        check_eq("t2_bubbles", n, LU_ST);
        check_eq("t2_stall_cnt", stall_cnt, LU_ST);
        check_eq("t2_ex_rd", ex_rd, 32'd6);
        check_eq("t2_fwd_a", fwd_a, FWD_LD);

        // back-to-back ALU dependency
        do_reset();
        step(1'b0, 1'b1, mk(OP_R, 5'd5, 5'd1, 5'd2), 1'b0, s, p, f);
        issue(mk(OP_R, 5'd8, 5'd5, 5'd5), n);
        check_eq("t3_bubbles", n, RAW_ST);
        check_eq("t3_stall_cnt", stall_cnt, RAW_ST);
        check_eq("t3_fwd_a", fwd_a, FWD_RAW);
        check_eq("t3_fwd_b", fwd_b, FWD_RAW);

        // flush beats load-use
        do_reset();
        step(1'b0, 1'b1, mk(OP_LD, 5'd5, 5'd1, 5'd0), 1'b0, s, p, f);
        step(1'b0, 1'b1, mk(OP_R, 5'd6, 5'd5, 5'd7), 1'b1, s, p, f);
        check_eq("t4_pc", p, 32'd1);
        check_eq("t4_flush", f, 32'd1);
        check_eq("t4_flush_cnt", flush_cnt, 32'd1);
        check_eq("t4_stall_cnt", stall_cnt, 32'd0);
        check_eq("t4_ex_bubble", {ex_regwrite, ex_memread, ex_op, ex_rd}, 32'd0);

        // x0 never hazards; LUI ignores rs1
        do_reset();
        step(1'b0, 1'b1, mk(OP_LD, 5'd0, 5'd1, 5'd0), 1'b0, s, p, f);
        issue(mk(OP_R, 5'd6, 5'd0, 5'd7), n);
        check_eq("t5_x0_bubbles", n, 32'd0);
        check_eq("t5_fwd", {fwd_a, fwd_b}, 32'd0);
        step(1'b0, 1'b1, mk(OP_LD, 5'd5, 5'd1, 5'd0), 1'b0, s, p, f);
        issue(mk(OP_LUI, 5'd9, 5'd5, 5'd5), n);
        check_eq("t5_lui_bubbles", n, 32'd0);

        // counter saturation, then reset during a stall
        do_reset();
        repeat (20) begin
            step(1'b0, 1'b1, mk(OP_LD, 5'd5, 5'd1, 5'd0), 1'b0, s, p, f);
            issue(mk(OP_R, 5'd6, 5'd5, 5'd7), n);
        end
        check_eq("t6_sat", stall_cnt, MAXC);
        step(1'b0, 1'b1, mk(OP_LD, 5'd5, 5'd1, 5'd0), 1'b0, s, p, f);
        step(1'b0, 1'b1, mk(OP_R, 5'd6, 5'd5, 5'd7), 1'b0, s, p, f);
        check_eq("t6_stalled", p, 32'd0);
        check_eq("t6_sat_hold", stall_cnt, MAXC);
        step(1'b1, 1'b1, mk(OP_R, 5'd6, 5'd5, 5'd7), 1'b0, s, p, f);
        check_eq("t6_rst_stages", {ex_regwrite, ex_memread, ex_rd, mem_regwrite, mem_rd, wb_regwrite, wb_rd}, 32'd0);
        step(1'b0, 1'b1, mk(OP_R, 5'd6, 5'd5, 5'd7), 1'b0, s, p, f);
        check_eq("t6_rst_pc", p, 32'd1);

        // random traffic, holding ID while stalled
        s = 1'b0;
        r = '0;
        for (int i = 0; i < 400; i++) begin
            if (!s) r = mk(ops[$urandom_range(0, 7)], 5'($urandom_range(0, 3)),
                           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            v = ($urandom_range(0, 7) != 0);
            br = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 79) == 0);
            step(rst, v, r, br, s, p, f);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
